sha3_absorb: RTL and testbench
==============================

// Module: sha3_absorb
// PURPOSE
// - Absorb stage in front of sha3_theta: collects 64-bit message lanes from a valid/ready stream.
// - XORs each lane into the rate part of the 5x5 Keccak state and presents the state on
//   osa..ose with a one-cycle `sample` pulse.
// - Reloads the state from the permutation output (ifa..ife, `ifeed`) between blocks.
// - After the final block is permuted, flags the digest state for the squeeze logic.
// PARAMETERS
// - RATE_LANES  17  rate in 64-bit lanes (17 = SHA3-256, 9 = SHA3-512); legal range 1..24.
// PORTS
// - clk           in   1       clock; the only clock.
// - rst           in   1       synchronous reset, active-high.
// - din           in   64      message lane, little-endian Keccak lane order.
// - din_valid     in   1       din is valid.
// - din_last      in   1       din is the final lane of the message.
// - din_ready     out  1       lane accepted when din_valid && din_ready.
// - ifa..ife      in   64x5    permuted state from the round chain, plane y=0..4, index x.
// - ifeed         in   1       one-cycle pulse: ifa..ife valid.
// - osa..ose      out  64x5    state register, plane y=0..4, index x; feeds sha3_theta isa..ise.
// - sample        out  1       one-cycle pulse: osa..ose hold a block to permute.
// - last_block    out  1       high together with sample when this block is the final one.
// - digest_valid  out  1       osa..ose hold the final permuted state; held until digest_ack.
// - digest_ack    in   1       consumer has taken the digest.
// BEHAVIOUR
// - Lane mapping: lane i -> x = i mod 5, y = i div 5. Lanes >= RATE_LANES are never written by din.
// - FSM states: COLLECT, ISSUE, WAIT_PERM, PAD (macro only), DONE. lane counter cnt, 0..RATE_LANES-1.
// - Reset (rst=1 at a clock edge): FSM=COLLECT, cnt=0, state=0, sample=0, last_block=0,
//   digest_valid=0, final flag=0. din_ready is 0 while rst is high.
// - COLLECT, output: din_ready=1.
// - COLLECT, on accept: lane[cnt] ^= din; cnt++.
// - COLLECT -> ISSUE, next cycle, when cnt==RATE_LANES-1 or din_last.
//   - On leaving COLLECT, cnt=0; final flag = din_last (see macro).
//   - Without the macro, an early din_last leaves the remaining rate lanes unmodified (XOR 0).
// - ISSUE: sample=1 and last_block=final flag, for exactly 1 cycle; din_ready=0; -> WAIT_PERM.
// - WAIT_PERM: din_ready=0. On ifeed: state <= ifa..ife (same edge), then:
//   - -> PAD if a pad block is pending;
//   - else -> DONE if final;
//   - else -> COLLECT.
// - ifeed outside WAIT_PERM is ignored. Two ifeed pulses must not occur in one WAIT_PERM.
// - DONE: digest_valid=1, din_ready=0. On digest_ack: state <= 0, final flag=0, -> COLLECT
//   (din_ready=1 on the next cycle).
// - Latency: sample rises 1 cycle after the accepting edge of the block's last lane.
// - No combinational path from din_valid to din_ready. din_ready depends only on FSM state and rst.
// - Reset mid-operation: all state is abandoned. A permutation result still in flight arrives
//   in COLLECT and is ignored.
// CONFIGURATION
// - SHA3_ABSORB_PADDING_EN defined: lane-granular SHA-3 pad10*1 with domain byte 0x06 is inserted
//   by hardware. Let k be the index of the lane carrying din_last:
//   - k+1 < RATE_LANES: lane[k+1] ^= 64'h06.
//   - Always, in the same block: lane[RATE_LANES-1] ^= 64'h80<<56. If k+1 == RATE_LANES-1, that
//     lane gets 64'h8000_0000_0000_0006.
//   - k == RATE_LANES-1: the data block is issued with last_block=0. After its ifeed the FSM enters
//     PAD (1 cycle), applies lane[0]^=06 and lane[RATE_LANES-1]^=80<<56, then goes to ISSUE with
//     last_block=1.
// - SHA3_ABSORB_PADDING_EN undefined: no padding. The PAD state does not exist. The host supplies
//   padded lanes. din_last marks the final block as-is.
// TESTING  (RATE_LANES=17)
// 1. Reset: rst 3 cycles, then low -> same cycle: din_ready=1. All outputs 0, osa..ose = 0.
// 2. No macro: 17 lanes 1..17, din_last on the 17th, din_valid held high ->
//    sample+last_block next cycle; osa[0]=1, osd[1]=17, lanes 17..24 = 0.
// 3. Continue 2: hold din_valid in WAIT_PERM -> din_ready=0, nothing accepted. Drive
//    ifeed with all lanes 64'hFFFF_FFFF_FFFF_FFFF -> next cycle digest_valid=1, osa[0]=all-ones.
//    digest_ack -> state 0, din_ready=1.
// 4. No macro, multi-block: 34 lanes of 0x5A, din_last on lane 34. Feed back zeros after block 1 ->
//    second sample has last_block=1; first sample has last_block=0.
// 5. Macro: message of 1 lane 0xAB -> osa[0]=0xAB, osa[1]=0x06, osd[1]=64'h8000_0000_0000_0000,
//    last_block=1.
//    Macro, 17-lane message -> 2 samples; second block osa[0]=0x06, osd[1]=0x80<<56.
// 6. Reset in WAIT_PERM, then ifeed pulse with all-ones -> ignored; osa..ose stay 0, FSM in COLLECT.

Source files
------------

// File: rtl/sha3_absorb_if.sv
// Stream, permutation-feedback and digest signals between sha3_absorb and its neighbours.
interface sha3_absorb_if;
   logic [63:0]       din;
   logic              din_valid;
   logic              din_last;
   logic              din_ready;
   logic [4:0][63:0]  ifa, ifb, ifc, ifd, ife;
   logic              ifeed;
   logic [4:0][63:0]  osa, osb, osc, osd, ose;
   logic              sample;
   logic              last_block;
   logic              digest_valid;
   logic              digest_ack;

   modport master (
      output din, din_valid, din_last, ifa, ifb, ifc, ifd, ife, ifeed, digest_ack,
      input  din_ready, osa, osb, osc, osd, ose, sample, last_block, digest_valid
   );

   modport slave (
      input  din, din_valid, din_last, ifa, ifb, ifc, ifd, ife, ifeed, digest_ack,
      output din_ready, osa, osb, osc, osd, ose, sample, last_block, digest_valid
   );
endinterface

// File: rtl/sha3_absorb.sv
// Keccak absorb stage: XORs message lanes into the rate, issues blocks, reloads permuted state.
// Optional hardware pad10*1 (domain 0x06) when SHA3_ABSORB_PADDING_EN is defined.
//
// state     | meaning
// COLLECT   | accepting lanes into the rate
// ISSUE     | one-cycle sample pulse, block ready for the permutation
// WAIT_PERM | waiting for ifeed to reload the state
// PAD       | extra pad-only block (padding macro only)
// DONE      | final permuted state held as digest until digest_ack
module sha3_absorb #(
   parameter int RATE_LANES = 17
) (
   input logic       clk,
   input logic       rst,
   sha3_absorb_if.slave io
);
   localparam logic [4:0]  LAST_LANE = 5'(RATE_LANES - 1);
   localparam logic [63:0] PAD_FIRST = 64'h0000_0000_0000_0006;
   localparam logic [63:0] PAD_LAST  = 64'h8000_0000_0000_0000;

`ifdef SHA3_ABSORB_PADDING_EN
   typedef enum logic [2:0] {COLLECT, ISSUE, WAIT_PERM, PAD, DONE} state_t;
   logic pad_q, pad_d;
`else
   typedef enum logic [2:0] {COLLECT, ISSUE, WAIT_PERM, DONE} state_t;
`endif

   state_t             state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic               final_q, final_d;
   logic [24:0][63:0]  lanes_q, lanes_d;
   logic               ready_c, sample_c, last_c, digest_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= COLLECT;
         cnt_q   <= '0;
         final_q <= 1'b0;
         lanes_q <= '0;
`ifdef SHA3_ABSORB_PADDING_EN
         pad_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         final_q <= final_d;
         lanes_q <= lanes_d;
`ifdef SHA3_ABSORB_PADDING_EN
         pad_q   <= pad_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      final_d  = final_q;
      lanes_d  = lanes_q;
`ifdef SHA3_ABSORB_PADDING_EN
      pad_d    = pad_q;
`endif
      ready_c  = 1'b0;
      sample_c = 1'b0;
      last_c   = 1'b0;
      digest_c = 1'b0;
      case (state_q)
         COLLECT: begin
            ready_c = !rst;
            if (io.din_valid && !rst) begin
               lanes_d[cnt_q] = lanes_q[cnt_q] ^ io.din;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == LAST_LANE || io.din_last) begin
                  state_d = ISSUE;
                  cnt_d   = '0;
                  final_d = io.din_last;
`ifdef SHA3_ABSORB_PADDING_EN
                  // last lane filling the rate: padding goes into a separate block
                  if (io.din_last) begin
                     if (cnt_q == LAST_LANE) begin
                        final_d = 1'b0;
                        pad_d   = 1'b1;
                     end else begin
                        lanes_d[cnt_q + 5'd1] = lanes_d[cnt_q + 5'd1] ^ PAD_FIRST;
                        lanes_d[LAST_LANE]    = lanes_d[LAST_LANE] ^ PAD_LAST;
                     end
                  end
`endif
               end
            end
         end
         ISSUE: begin
            sample_c = 1'b1;
            last_c   = final_q;
            state_d  = WAIT_PERM;
         end
         WAIT_PERM: begin
            if (io.ifeed) begin
               lanes_d = {io.ife, io.ifd, io.ifc, io.ifb, io.ifa};
`ifdef SHA3_ABSORB_PADDING_EN
               if (pad_q)        state_d = PAD;
               else if (final_q) state_d = DONE;
               else              state_d = COLLECT;
`else
               state_d = final_q ? DONE : COLLECT;
`endif
            end
         end
`ifdef SHA3_ABSORB_PADDING_EN
         PAD: begin
            lanes_d[0]         = lanes_q[0] ^ PAD_FIRST;
            lanes_d[LAST_LANE] = lanes_d[LAST_LANE] ^ PAD_LAST;
            final_d = 1'b1;
            pad_d   = 1'b0;
            state_d = ISSUE;
         end
`endif
         DONE: begin
            digest_c = 1'b1;
            if (io.digest_ack) begin
               lanes_d = '0;
               final_d = 1'b0;
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   assign io.din_ready    = ready_c;
   assign io.sample       = sample_c;
   assign io.last_block   = last_c;
   assign io.digest_valid = digest_c;
   assign io.osa = lanes_q[4:0];
   assign io.osb = lanes_q[9:5];
   assign io.osc = lanes_q[14:10];
   assign io.osd = lanes_q[19:15];
   assign io.ose = lanes_q[24:20];
endmodule

// File: tb/tb_sha3_absorb.sv
// Bench for sha3_absorb: message-level reference model splits messages into blocks and pads them.
module tb_sha3_absorb;
   localparam int R = 17;
   localparam logic [63:0] PAD_FIRST = 64'h0000_0000_0000_0006;
   localparam logic [63:0] PAD_LAST  = 64'h8000_0000_0000_0000;
   typedef logic [24:0][63:0] st_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sha3_absorb_if bus ();
   sha3_absorb #(.RATE_LANES(R)) dut (.clk(clk), .rst(rst), .io(bus));

   int checks = 0;
   int errors = 0;

   logic [63:0] msg [$];
   st_t         blk_q [$];
   int          nl_q [$];
   bit          lf_q [$];

   function automatic st_t dut_state();
      return {bus.ose, bus.osd, bus.osc, bus.osb, bus.osa};
   endfunction

   function automatic int first_diff(input st_t a, input st_t b);
      for (int i = 0; i < 25; i++) if (a[i] !== b[i]) return i;
      return 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_fb(input st_t fb);
      bus.ifa = fb[4:0];
      bus.ifb = fb[9:5];
      bus.ifc = fb[14:10];
      bus.ifd = fb[19:15];
      bus.ife = fb[24:20];
   endtask

   function automatic st_t rand_state();
      st_t s;
      for (int i = 0; i < 25; i++) s[i] = {$urandom, $urandom};
      return s;
   endfunction

   task automatic idle_inputs();
      bus.din = '0;
      bus.din_valid = 1'b0;
      bus.din_last = 1'b0;
      bus.ifeed = 1'b0;
      bus.digest_ack = 1'b0;
      drive_fb('0);
   endtask

   // Blocks are rate-sized chunks of the message; the final chunk may be short.
   task automatic build_model();
      int n;
      int nb;
      n  = msg.size();
      nb = (n + R - 1) / R;
      blk_q.delete();
      nl_q.delete();
      lf_q.delete();
      for (int b = 0; b < nb; b++) begin
         st_t blk;
         int  cnt;
         bit  extra;
         int  k;
         blk = '0;
         cnt = 0;
         extra = 1'b0;
         k = (n - 1) % R;
         for (int i = 0; i < R; i++) begin
            if (b * R + i < n) begin
               blk[i] = msg[b * R + i];
               cnt++;
            end
         end
`ifdef SHA3_ABSORB_PADDING_EN
         if (b == nb - 1) begin
            if (k < R - 1) begin
               blk[k + 1] = blk[k + 1] ^ PAD_FIRST;
               blk[R - 1] = blk[R - 1] ^ PAD_LAST;
            end else begin
               extra = 1'b1;
            end
         end
`endif
         blk_q.push_back(blk);
         nl_q.push_back(cnt);
         lf_q.push_back((b == nb - 1) && !extra);
         if (extra) begin
            st_t p;
            p = '0;
            p[0] = p[0] ^ PAD_FIRST;
            p[R - 1] = p[R - 1] ^ PAD_LAST;
            blk_q.push_back(p);
            nl_q.push_back(0);
            lf_q.push_back(1'b1);
         end
      end
   endtask

   // fb_mode: 0 random, 1 zeros, 2 all ones
   task automatic run_message(input int fb_mode, input bit hold_valid, input bit gaps);
      st_t prev;
      st_t fb;
      st_t exp;
      st_t got;
      int  mi;
      int  n;
      prev = '0;
      mi = 0;
      build_model();
      n = msg.size();
      for (int b = 0; b < blk_q.size(); b++) begin
         for (int j = 0; j < nl_q[b]; j++) begin
            if (gaps) begin
               repeat ($urandom_range(2, 0)) begin
                  bus.din_valid = 1'b0;
                  bus.din = {$urandom, $urandom};
                  checks++;
                  if (bus.din_ready !== 1'b1) begin
                     errors++;
                     $display("FAIL ready_idle: got %b want 1", bus.din_ready);
                  end
                  tick();
               end
            end
            bus.din = msg[mi];
            bus.din_valid = 1'b1;
            bus.din_last = (mi == n - 1);
            checks++;
            if (bus.din_ready !== 1'b1) begin
               errors++;
               $display("FAIL ready_collect b=%0d lane=%0d: got %b want 1", b, j, bus.din_ready);
            end
            tick();
            mi++;
         end
         bus.din_last = 1'b0;
         if (hold_valid) begin
            bus.din = {$urandom, $urandom};
            bus.din_valid = 1'b1;
         end else begin
            bus.din_valid = 1'b0;
         end
         exp = prev ^ blk_q[b];
         got = dut_state();
         checks++;
         if (bus.sample !== 1'b1) begin
            errors++;
            $display("FAIL sample_rise b=%0d: got %b want 1", b, bus.sample);
         end
         checks++;
         if (bus.last_block !== lf_q[b]) begin
            errors++;
            $display("FAIL last_block b=%0d: got %b want %b", b, bus.last_block, lf_q[b]);
         end
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL block_state b=%0d lane %0d: got %h want %h", b,
                     first_diff(got, exp), got[first_diff(got, exp)], exp[first_diff(got, exp)]);
         end
         checks++;
         if (bus.din_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_issue b=%0d: got %b want 0", b, bus.din_ready);
         end
         tick();
         checks++;
         if (bus.sample !== 1'b0 || bus.din_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_perm b=%0d: sample %b ready %b want 0 0", b, bus.sample, bus.din_ready);
         end
         repeat ($urandom_range(2, 0)) begin
            tick();
            checks++;
            if (bus.din_ready !== 1'b0) begin
               errors++;
               $display("FAIL ready_wait b=%0d: got %b want 0", b, bus.din_ready);
            end
         end
         case (fb_mode)
            1:       fb = '0;
            2:       fb = '1;
            default: fb = rand_state();
         endcase
         drive_fb(fb);
         bus.ifeed = 1'b1;
         bus.din_valid = 1'b0;
         tick();
         bus.ifeed = 1'b0;
         drive_fb(rand_state());
         prev = fb;
         got = dut_state();
         if (b + 1 < blk_q.size() && nl_q[b + 1] == 0) begin
            checks++;
            if (bus.sample !== 1'b0 || got !== fb) begin
               errors++;
               $display("FAIL pad_cycle b=%0d: sample %b lane0 %h want 0 %h", b, bus.sample, got[0], fb[0]);
            end
            tick();
         end else if (lf_q[b]) begin
            checks++;
            if (bus.digest_valid !== 1'b1 || bus.din_ready !== 1'b0) begin
               errors++;
               $display("FAIL digest_valid: valid %b ready %b want 1 0", bus.digest_valid, bus.din_ready);
            end
            checks++;
            if (got !== fb) begin
               errors++;
               $display("FAIL digest_state lane %0d: got %h want %h", first_diff(got, fb),
                        got[first_diff(got, fb)], fb[first_diff(got, fb)]);
            end
            repeat (2) begin
               tick();
               checks++;
               if (bus.digest_valid !== 1'b1) begin
                  errors++;
                  $display("FAIL digest_hold: got %b want 1", bus.digest_valid);
               end
            end
            bus.digest_ack = 1'b1;
            tick();
            bus.digest_ack = 1'b0;
            got = dut_state();
            checks++;
            if (bus.digest_valid !== 1'b0 || bus.din_ready !== 1'b1 || got !== '0) begin
               errors++;
               $display("FAIL after_ack: valid %b ready %b lane%0d %h want 0 1 0", bus.digest_valid,
                        bus.din_ready, first_diff(got, '0), got[first_diff(got, '0)]);
            end
         end else begin
            checks++;
            if (bus.din_ready !== 1'b1 || got !== fb) begin
               errors++;
               $display("FAIL next_collect b=%0d: ready %b lane0 %h want 1 %h", b, bus.din_ready, got[0], fb[0]);
            end
         end
      end
      bus.din_valid = 1'b0;
   endtask

   task automatic test_reset();
      st_t got;
      idle_inputs();
      rst = 1'b1;
      repeat (3) begin
         tick();
         checks++;
         if (bus.din_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset: got %b want 0", bus.din_ready);
         end
      end
      rst = 1'b0;
      #1;
      got = dut_state();
      checks++;
      if (bus.din_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b want 1", bus.din_ready);
      end
      checks++;
      if (bus.sample !== 1'b0 || bus.last_block !== 1'b0 || bus.digest_valid !== 1'b0) begin
         errors++;
         $display("FAIL outputs_reset: sample %b last %b digest %b want 0 0 0",
                  bus.sample, bus.last_block, bus.digest_valid);
      end
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL state_reset lane %0d: got %h want 0", first_diff(got, '0), got[first_diff(got, '0)]);
      end
   endtask

   task automatic test_single_block();
      msg.delete();
      for (int i = 1; i <= R; i++) msg.push_back(64'(i));
      run_message(2, 1'b1, 1'b0);
   endtask

   task automatic test_multi_block();
      msg.delete();
      for (int i = 0; i < 2 * R; i++) msg.push_back(64'h5A);
      run_message(1, 1'b0, 1'b0);
   endtask

   task automatic test_short_message();
      msg.delete();
      for (int i = 0; i < 5; i++) msg.push_back({$urandom, $urandom});
      run_message(0, 1'b0, 1'b1);
   endtask

`ifdef SHA3_ABSORB_PADDING_EN
   task automatic test_padding();
      msg.delete();
      msg.push_back(64'hAB);
      run_message(0, 1'b0, 1'b0);
      msg.delete();
      for (int i = 0; i < R; i++) msg.push_back({$urandom, $urandom});
      run_message(0, 1'b0, 1'b1);
      msg.delete();
      for (int i = 0; i < R - 1; i++) msg.push_back({$urandom, $urandom});
      run_message(0, 1'b0, 1'b0);
   endtask
`endif

   task automatic test_reset_inflight();
      st_t got;
      for (int i = 0; i < R; i++) begin
         bus.din = {$urandom, $urandom};
         bus.din_valid = 1'b1;
         bus.din_last = 1'b0;
         tick();
      end
      bus.din_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive_fb('1);
      bus.ifeed = 1'b1;
      tick();
      bus.ifeed = 1'b0;
      got = dut_state();
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL stale_ifeed lane %0d: got %h want 0", first_diff(got, '0), got[first_diff(got, '0)]);
      end
      checks++;
      if (bus.din_ready !== 1'b1 || bus.sample !== 1'b0 || bus.digest_valid !== 1'b0) begin
         errors++;
         $display("FAIL collect_after_reset: ready %b sample %b digest %b want 1 0 0",
                  bus.din_ready, bus.sample, bus.digest_valid);
      end
      msg.delete();
      for (int i = 0; i < 3; i++) msg.push_back({$urandom, $urandom});
      run_message(0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 8; t++) begin
         int len;
         len = $urandom_range(3 * R, 1);
         msg.delete();
         for (int i = 0; i < len; i++) msg.push_back({$urandom, $urandom});
         run_message(0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_multi_block();
      test_short_message();
`ifdef SHA3_ABSORB_PADDING_EN
      test_padding();
`endif
      test_reset_inflight();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
